fifo_word_packer: RTL and testbench

Read-side consumer for the team's synchronous byte FIFO (`syncFifo`). It pops bytes whenever the FIFO is non-empty and packs `LANES` consecutive bytes into one word. Each word is presented on a valid/ready stream to the downstream datapath. The block is the drain end of the FIFO: it owns the FIFO `rd` strobe and never underflows the FIFO.

---
 rtl/fifo_pack_pkg.sv | 22 ++
 rtl/pack_timer.sv | 39 +++
 rtl/fifo_word_packer.sv | 110 +++++++++++
 tb/tb_fifo_word_packer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pack_pkg.sv
// Shared types for the FIFO word packer: FSM state encoding and a width helper.
package fifo_pack_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_e;

  // Bits needed to hold values 0..value-1; never less than 1.
  function automatic int clog2(input int value);
    int w;
    int v;
    w = 0;
    v = value - 1;
    while (v > 0) begin
      w++;
      v = v >> 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pack_timer.sv
// Idle counter: expired pulses on the LIMIT-th consecutive tick; clear wins over tick.
// Single-cycle combinational expiry, no backpressure of its own.
module pack_timer
  import fifo_pack_pkg::*;
#(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int TW = clog2(LIMIT + 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick) begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = tick && (count_q == TW'(LIMIT - 1));

endmodule

// File: rtl/fifo_word_packer.sv
// Drains a byte FIFO into LANES-byte words on valid/ready; first fifo_rd in cycle 0, m_valid from cycle LANES+1.
// No reads while a word waits on m_ready; PACK_TIMEOUT_EN flushes stalled partial words after TIMEOUT_CYCLES.
module fifo_word_packer
  import fifo_pack_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int LANES          = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        fifo_rd,
  input  logic [DATA_WIDTH-1:0]       fifo_data,
  input  logic                        fifo_empty,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_WIDTH*LANES-1:0] m_data,
  output logic [LANES-1:0]            m_keep
);

  localparam int CW = clog2(LANES + 1);

  if (LANES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("fifo_word_packer: LANES must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  pack_state_e                 state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        inflight_q;
  logic [DATA_WIDTH*LANES-1:0] data_q, data_d;
  logic [LANES-1:0]            keep_q, keep_d;

  logic        xfer;
  logic        capture;
  logic        rd;
  logic        timeout;
  logic [CW:0] pending;

  assign xfer    = (state_q == HOLD) && m_ready;
  assign capture = inflight_q;

  // A completing transfer frees the whole word, so the next word's first read can issue in the same cycle.
  assign pending = (xfer ? '0 : {1'b0, cnt_q}) + {{CW{1'b0}}, inflight_q};
  assign rd      = !rst && !fifo_empty && (pending < (CW+1)'(LANES)) &&
                   ((state_q == FILL) || xfer);

`ifdef PACK_TIMEOUT_EN
  pack_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_pack_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (capture || (state_q != FILL)),
    .tick    ((state_q == FILL) && (cnt_q != '0) && !capture && !rd),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    keep_d  = keep_q;

    for (int l = 0; l < LANES; l++) begin
      if (capture && (cnt_q == CW'(l))) begin
        data_d[l*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
        keep_d[l]                          = 1'b1;
      end
    end
    if (capture) begin
      cnt_d = cnt_q + CW'(1);
    end

    if (state_q == FILL) begin
      if ((capture && (cnt_q == CW'(LANES - 1))) || timeout) begin
        state_d = HOLD;
      end
    end else if (m_ready) begin
      state_d = FILL;
      cnt_d   = '0;
      data_d  = '0;
      keep_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      data_q     <= '0;
      keep_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inflight_q <= rd;
      data_q     <= data_d;
      keep_q     <= keep_d;
    end
  end

  assign fifo_rd = rd;
  assign m_valid = (state_q == HOLD);
  assign m_data  = data_q;
  assign m_keep  = keep_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: behavioural byte FIFO, word scoreboard, directed timing checks.
module tb_fifo_word_packer;

  localparam int DW = 8;
  localparam int LN = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_rd;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_empty;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW*LN-1:0] m_data;
  logic [LN-1:0] m_keep;

  always #5 clk = ~clk;

  fifo_word_packer #(
    .DATA_WIDTH     (DW),
    .LANES          (LN),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_rd    (fifo_rd),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_keep     (m_keep)
  );

  // Behavioural syncFifo read side: data_out valid the cycle after rd.
  logic [7:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  typedef struct packed {
    logic [31:0] dat;
    logic [3:0]  keep;
  } word_t;

  word_t       exp_q[$];
  logic [31:0] part_dat  = '0;
  logic [3:0]  part_keep = '0;
  int          part_cnt  = 0;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int rd_pulses = 0;
  int acc_cyc[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr      = wr_ptr + 1;
    part_dat[part_cnt*8 +: 8] = b;
    part_keep[part_cnt]       = 1'b1;
    part_cnt++;
    if (part_cnt == LN) begin
      exp_q.push_back({part_dat, part_keep});
      part_dat  = '0;
      part_keep = '0;
      part_cnt  = 0;
    end
  endtask

  task automatic drop_partial();
    part_dat  = '0;
    part_keep = '0;
    part_cnt  = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk(tag, exp_q.size(), 0);
    tick(1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    @(negedge clk);
    for (int i = 0; i < budget && !m_valid; i++) @(negedge clk);
    chk(tag, m_valid, 1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fifo_rd) begin
      rd_pulses++;
      chk("rd_while_empty", fifo_empty, 0);
      chk("rd_in_reset", rst, 0);
    end
    if (!rst && m_valid && m_ready) begin
      acc_cyc.push_back(cyc);
      chk("word_available", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        word_t w;
        w = exp_q.pop_front();
        chk("sb_data", m_data, w.dat);
        chk("sb_keep", m_keep, w.keep);
      end
    end
  end

  initial begin
    int          first_v;
    int          r0;
    int          a0;
    int          t0;
    int          unstable;
    logic [31:0] d0;
    logic [3:0]  k0;

    // Reset with the FIFO already holding a word.
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_fifo_rd", fifo_rd, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_keep", m_keep, 0);
    chk("rst_no_pops", rd_ptr, 0);

    // Basic pack and latency from an idle, non-empty FIFO.
    m_ready = 1'b1;
    @(posedge clk); #1;
    rst     = 1'b0;
    r0      = rd_pulses;
    first_v = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) chk("first_rd_cycle0", fifo_rd, 1);
      if (m_valid && first_v < 0) begin
        first_v = c;
        chk("basic_data", m_data, 32'h44332211);
        chk("basic_keep", m_keep, 4'hF);
      end
    end
    chk("basic_valid_cycle", first_v, LN + 1);
    chk("basic_rd_pulses", rd_pulses - r0, 4);
    chk("basic_drained", exp_q.size(), 0);
    tick(1);

    // Backpressure: two words queued, m_ready low for 10 cycles.
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_byte(8'hA0 + 8'(i));
    wait_valid("bp_wait_valid", 30);
    d0 = m_data;
    k0 = m_keep;
    chk("bp_word0", d0, 32'hA3A2A1A0);
    r0       = rd_pulses;
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_data !== d0 || m_keep !== k0 || m_valid !== 1'b1) unstable++;
    end
    chk("bp_stable", unstable, 0);
    chk("bp_no_reads", rd_pulses - r0, 0);
    tick(1);
    a0      = acc_cyc.size();
    m_ready = 1'b1;
    wait_drain("bp_drain", 40);
    chk("bp_words", acc_cyc.size() - a0, 2);
    if (acc_cyc.size() >= a0 + 2) chk("b2b_gap", acc_cyc[a0+1] - acc_cyc[a0], LN + 1);

    // Underflow guard: FIFO runs dry mid-word.
    push_byte(8'h5A); push_byte(8'h6B);
    r0 = rd_pulses;
    tick(10);
    @(negedge clk);
    chk("uf_no_valid", m_valid, 0);
    chk("uf_rd_pulses", rd_pulses - r0, 2);
    tick(1);
    push_byte(8'h7C); push_byte(8'h8D);
    wait_drain("uf_drain", 20);

    // Partial word: flushed after the idle timeout, or held until completed.
    push_byte(8'hA1); push_byte(8'hB2); push_byte(8'hC3);
`ifdef PACK_TIMEOUT_EN
    t0 = cyc;
    exp_q.push_back({part_dat, part_keep});
    drop_partial();
    wait_valid("to_wait_valid", 40);
    chk("to_valid_cycle", cyc - t0, 3 + TO + 1);
    chk("to_data", m_data, 32'h00C3B2A1);
    chk("to_keep", m_keep, 4'h7);
    tick(1);
    wait_drain("to_drain", 10);
`else
    t0 = cyc;
    tick(40);
    @(negedge clk);
    chk("partial_waits", m_valid, 0);
    chk("partial_keep", m_keep, 4'h7);
    chk("partial_elapsed", cyc - t0 >= 40, 1);
    tick(1);
    push_byte(8'h44);
    wait_drain("partial_drain", 20);
`endif

    // Reset after two captures discards the partial word.
    push_byte(8'hAA); push_byte(8'hBB);
    tick(6);
    @(negedge clk);
    chk("mid_keep", m_keep, 4'h3);
    @(posedge clk); #1;
    rst = 1'b1;
    drop_partial();
    tick(2);
    @(negedge clk);
    chk("mid_rst_data", m_data, 0);
    chk("mid_rst_keep", m_keep, 0);
    chk("mid_rst_valid", m_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_byte(8'h04);
    wait_drain("mid_drain", 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
